// File: rtl/ifu.sv
// ifu: RV32E multi-cycle instruction fetch unit.
// Owns the PC, fetches one word at a time and hands it to decode over valid/ready.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    // state | meaning
    // REQ   | fetch request presented on imem
    // WAIT  | exactly one request outstanding
    // HOLD  | instruction held for decode

    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt, inst_nxt, target;
    logic        fault_nxt, kill, kill_nxt, req_fire;

    assign target         = {redirect_pc[31:2], 2'b00};
    assign imem_req_valid = (state == REQ) && !rst;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD);
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_fault <= 1'b0;
            kill       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst       <= inst_nxt;
            inst_fault <= fault_nxt;
            kill       <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst;
        fault_nxt = inst_fault;
        kill_nxt  = kill;
        case (state)
            REQ: begin
                if (req_fire) state_nxt = WAIT;
                // a request accepted alongside a redirect fetches the stale PC; drop its response
                if (redirect_valid) begin
                    pc_nxt   = target;
                    kill_nxt = req_fire;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt = target;
                    if (imem_rsp_valid) begin
                        state_nxt = REQ;
                        kill_nxt  = 1'b0;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        inst_nxt  = imem_rsp_err ? 32'h0 : imem_rsp_data;
                        fault_nxt = imem_rsp_err;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = target;
                    state_nxt = REQ;
                end else if (inst_ready) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed vector table for the fetch/decode handshakes plus a randomized
// run checked against a PC-sequence model and an address-hashed memory.
module tb_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0, imem_rsp_err = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid, inst_ready = 1'b0, inst_fault;
    logic [31:0] inst, pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    always #5 clk = ~clk;

    ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
        .inst_fault(inst_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          rdy_dly;
        int          rsp_lat;
        logic [31:0] data;
        logic        err;
        int          dec_dly;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[5:2] == 4'hB;
    endfunction

    // One full fetch: request (optionally stalled), response after rsp_lat cycles, decode stall.
    task automatic run_vec(input vec_t v, output int t_valid);
        int   n;
        logic held;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", imem_req_valid, 1);
        held = 1'b1;
        for (int d = 0; d < v.rdy_dly; d++) begin
            imem_req_ready = 1'b0;
            if (imem_req_addr !== v.exp_pc || imem_req_valid !== 1'b1) held = 1'b0;
            @(negedge clk);
        end
        if (v.rdy_dly > 0) check("req_addr_held", held, 1);
        check("req_addr", imem_req_addr, v.exp_pc);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("single_accept", imem_req_valid, 0);
        for (int l = 1; l < v.rsp_lat; l++) @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = v.data;
        imem_rsp_err   = v.err;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        t_valid = cyc;
        check("inst_valid", inst_valid, 1);
        check("inst", inst, v.exp_inst);
        check("inst_pc", pc, v.exp_pc);
        check("inst_fault", inst_fault, v.exp_fault);
        held = 1'b1;
        for (int d = 0; d < v.dec_dly; d++) begin
            inst_ready = 1'b0;
            @(negedge clk);
            if (inst_valid !== 1'b1 || inst !== v.exp_inst || pc !== v.exp_pc || imem_req_valid !== 1'b0)
                held = 1'b0;
        end
        if (v.dec_dly > 0) check("hold_stable", held, 1);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check("next_req_valid", imem_req_valid, 1);
        check("next_req_addr", imem_req_addr, v.exp_pc + 32'd4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t[7];
        int          tv;
        vec_t        v;
        logic [31:0] exp_pc, oaddr;
        logic        outst, pending;
        int          lat, delivered;

        tbl[0] = '{0, 1, 32'h0000_0013, 1'b0, 0, 32'h8000_0000, 32'h0000_0013, 1'b0};
        tbl[1] = '{0, 1, 32'h0010_0093, 1'b0, 0, 32'h8000_0004, 32'h0010_0093, 1'b0};
        tbl[2] = '{0, 1, 32'h0020_8113, 1'b0, 0, 32'h8000_0008, 32'h0020_8113, 1'b0};
        tbl[3] = '{4, 1, 32'hDEAD_BEEF, 1'b0, 0, 32'h8000_000C, 32'hDEAD_BEEF, 1'b0};
        tbl[4] = '{0, 2, 32'h1234_5678, 1'b0, 5, 32'h8000_0010, 32'h1234_5678, 1'b0};
        tbl[5] = '{0, 1, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0014, 32'h0000_0000, 1'b1};
        tbl[6] = '{0, 3, 32'h0000_A0B7, 1'b0, 1, 32'h8000_0018, 32'h0000_A0B7, 1'b0};

        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", inst, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_fault", inst_fault, 0);
        rst = 1'b0;
        #1;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, RESET_PC);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], t[i]);
        check("throughput_1", t[1] - t[0], 3);
        check("throughput_2", t[2] - t[1], 3);

        // redirect while waiting, response arrives two cycles later and must be dropped
        check("redir_req_addr", imem_req_addr, 32'h8000_001C);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("redir_no_req", imem_req_valid, 0);
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("redir_discard", inst_valid, 0);
        check("redir_new_req", imem_req_valid, 1);
        check("redir_new_addr", imem_req_addr, 32'h8000_0100);
        v = '{0, 1, 32'h0000_0297, 1'b0, 0, 32'h8000_0100, 32'h0000_0297, 1'b0};
        run_vec(v, tv);

        // reset pulse mid-WAIT, stale response one cycle after release
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_req_valid", imem_req_valid, 0);
        check("arst_pc", pc, RESET_PC);
        check("arst_inst_valid", inst_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("stale_ignored", inst_valid, 0);
        check("stale_req_valid", imem_req_valid, 1);
        check("stale_req_addr", imem_req_addr, RESET_PC);
        v = '{0, 1, 32'h0000_0013, 1'b0, 0, RESET_PC, 32'h0000_0013, 1'b0};
        run_vec(v, tv);

        // random run: next delivered PC is last redirect target or last consumed PC + 4
        exp_pc    = RESET_PC + 32'd4;
        outst     = 1'b0;
        oaddr     = 32'h0;
        lat       = 0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            pending        = outst;
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            if (outst) begin
                if (lat == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(oaddr);
                    imem_rsp_err   = mem_err(oaddr);
                    outst          = 1'b0;
                end else begin
                    lat--;
                end
            end
            if (imem_req_valid) check("one_outstanding", pending, 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 32'h8000_0000 | 32'($urandom_range(0, 4095));
            if (inst_valid) begin
                check("rnd_pc", pc, exp_pc);
                check("rnd_inst", inst, mem_err(exp_pc) ? 32'h0 : mem_word(exp_pc));
                check("rnd_fault", inst_fault, mem_err(exp_pc));
                if (inst_ready) delivered++;
            end
            if (imem_req_valid && imem_req_ready) begin
                if (!redirect_valid) check("rnd_req_addr", imem_req_addr, exp_pc);
                outst = 1'b1;
                oaddr = imem_req_addr;
                lat   = $urandom_range(0, 3);
            end
            if (redirect_valid)
                exp_pc = {redirect_pc[31:2], 2'b00};
            else if (inst_valid && inst_ready)
                exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        check("rnd_progress", (delivered >= 100) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
